// File: rtl/alu_op_encoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_encoder
// Purpose  : Decodes an instruction's ALUOp class, funct3 and funct7 fields
//            into an ALU operation code, behind a one-deep valid/ready
//            register stage. Illegal decodes are flagged and counted
//            (saturating at 255).
// Ports    : clk           - rising-edge clock
//            reset         - asynchronous reset, active-low
//            in_valid      - decode request present
//            in_ready      - request accepted this cycle
//            ALUOp         - 00 ld/st, 01 branch, 10 arithmetic, 11 LUI
//            Funct3        - instruction funct3 field
//            Funct7        - instruction funct7 field (only bit 5 is used)
//            RType         - 1 = register-register form
//            flush         - discard the held / incoming result
//            out_valid     - Operation/illegal are valid
//            out_ready     - consumer accepts Operation this cycle
//            Operation     - registered ALU operation code
//            illegal       - registered illegal-decode flag
//            illegal_count - saturating count of accepted illegal decodes
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_encoder #(
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     RType,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [7:0]               illegal_count
);

    // Operation codes, zero-extended to the configured width.
    localparam logic [OPCODE_LENGTH-1:0] c_OP_AND  = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_OR   = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_ADD  = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SUB  = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_XOR  = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRL  = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLL  = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRA  = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BEQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_LUI  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BNE  = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BLT  = OPCODE_LENGTH'(4'b1011);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_BGE  = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLT  = OPCODE_LENGTH'(4'b1110);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_NONE = '0;
    localparam logic [7:0]               c_CNT_MAX = 8'hFF;

    logic [OPCODE_LENGTH-1:0] r_operation;
    logic                     r_illegal;
    logic                     r_out_valid;
    logic [7:0]               r_illegal_count;

    logic [OPCODE_LENGTH-1:0] w_op;
    logic                     w_illegal;
    logic                     w_xfer;
    logic                     w_alt;

    // Only Funct7[5] selects the alternate (SUB / SRA) encoding.
    assign w_alt = Funct7[5];

    // Remaining funct7 bits are architecturally don't-care.
    logic w_unused_funct7;
    assign w_unused_funct7 = &{1'b0, Funct7[6], Funct7[4:0]};

    always_comb begin
        w_op      = c_OP_NONE;
        w_illegal = 1'b0;
        case (ALUOp)
            2'b00: w_op = c_OP_ADD;
            2'b11: w_op = c_OP_LUI;
            2'b01: begin
                case (Funct3)
                    3'b000:  w_op = c_OP_BEQ;
                    3'b001:  w_op = c_OP_BNE;
                    3'b100:  w_op = c_OP_BLT;
                    3'b101:  w_op = c_OP_BGE;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: begin
                case (Funct3)
                    // Immediate forms have no SUB, so the alt bit only
                    // matters for register-register ADD.
                    3'b000:  w_op = (RType && w_alt) ? c_OP_SUB : c_OP_ADD;
                    3'b001:  w_op = c_OP_SLL;
                    3'b010:  w_op = c_OP_SLT;
                    3'b100:  w_op = c_OP_XOR;
                    3'b101:  w_op = w_alt ? c_OP_SRA : c_OP_SRL;
                    3'b110:  w_op = c_OP_OR;
                    3'b111:  w_op = c_OP_AND;
                    default: w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid     <= 1'b0;
            r_operation     <= c_OP_NONE;
            r_illegal       <= 1'b0;
            r_illegal_count <= 8'd0;
        end else begin
            // Flush wins over any concurrent transfer and keeps that
            // request out of the illegal count.
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_operation <= w_op;
                r_illegal   <= w_illegal;
                if (w_illegal && (r_illegal_count != c_CNT_MAX)) begin
                    r_illegal_count <= r_illegal_count + 8'd1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign Operation     = r_operation;
    assign illegal       = r_illegal;
    assign illegal_count = r_illegal_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_encoder
// Purpose  : Directed self-checking bench for alu_op_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_encoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] ALUOp;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       RType;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Operation;
    logic       illegal;
    logic [7:0] illegal_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    alu_op_encoder #(.OPCODE_LENGTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ALUOp         (ALUOp),
        .Funct3        (Funct3),
        .Funct7        (Funct7),
        .RType         (RType),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Operation     (Operation),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted request with out_ready=1, then check the registered result.
    task automatic xfer(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic rt,
                        input logic [3:0] exp_op, input logic exp_ill);
        ALUOp = op; Funct3 = f3; Funct7 = f7; RType = rt;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        if (exp_ill) exp_cnt++;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_op"},    32'(Operation), 32'(exp_op));
        chk({tag, "_ill"},   32'(illegal),   32'(exp_ill));
        chk({tag, "_cnt"},   32'(illegal_count), 32'(exp_cnt));
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        ALUOp = 2'b00; Funct3 = 3'b000; Funct7 = 7'd0; RType = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_op",    32'(Operation), 32'd0);
        chk("rst_ill",   32'(illegal),   32'd0);
        chk("rst_cnt",   32'(illegal_count), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        tick();
        tick();
        reset = 1'b1;
        chk("rel_ready", 32'(in_ready), 32'd1);

        // Arithmetic ADD/SUB and shifts
        xfer("sub",   2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0011, 1'b0);
        xfer("addi",  2'b10, 3'b000, 7'b0100000, 1'b0, 4'b0010, 1'b0);
        xfer("add",   2'b10, 3'b000, 7'b0000000, 1'b1, 4'b0010, 1'b0);
        xfer("sra",   2'b10, 3'b101, 7'b0100000, 1'b1, 4'b0111, 1'b0);
        xfer("srl",   2'b10, 3'b101, 7'b0000000, 1'b1, 4'b0101, 1'b0);
        xfer("srl_f7", 2'b10, 3'b101, 7'b1011111, 1'b1, 4'b0101, 1'b0);
        xfer("sub_f7", 2'b10, 3'b000, 7'b1011111, 1'b1, 4'b0010, 1'b0);
        xfer("sll",   2'b10, 3'b001, 7'b0000000, 1'b1, 4'b0110, 1'b0);
        xfer("slt",   2'b10, 3'b010, 7'b0000000, 1'b0, 4'b1110, 1'b0);
        xfer("xor",   2'b10, 3'b100, 7'b0000000, 1'b1, 4'b0100, 1'b0);
        xfer("or",    2'b10, 3'b110, 7'b0000000, 1'b1, 4'b0001, 1'b0);
        xfer("and",   2'b10, 3'b111, 7'b0000000, 1'b1, 4'b0000, 1'b0);
        // Load/store and LUI ignore funct fields
        xfer("ldst",  2'b00, 3'b111, 7'b1111111, 1'b1, 4'b0010, 1'b0);
        xfer("lui",   2'b11, 3'b011, 7'b0100000, 1'b0, 4'b1001, 1'b0);
        // Branches
        xfer("beq",   2'b01, 3'b000, 7'b0000000, 1'b0, 4'b1000, 1'b0);
        xfer("bne",   2'b01, 3'b001, 7'b0000000, 1'b0, 4'b1010, 1'b0);
        xfer("blt",   2'b01, 3'b100, 7'b0000000, 1'b0, 4'b1011, 1'b0);
        xfer("bge",   2'b01, 3'b101, 7'b0100000, 1'b0, 4'b1100, 1'b0);
        // Illegal decodes
        xfer("ill_ar", 2'b10, 3'b011, 7'b0000000, 1'b1, 4'b0000, 1'b1);
        xfer("ill_br", 2'b01, 3'b110, 7'b0000000, 1'b0, 4'b0000, 1'b1);

        // Backpressure: hold 0110 for three cycles
        xfer("bp_sll", 2'b10, 3'b001, 7'b0000000, 1'b0, 4'b0110, 1'b0);
        out_ready = 1'b0;
        ALUOp = 2'b10; Funct3 = 3'b100; in_valid = 1'b1;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_op",    32'(Operation), 32'h6);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready1", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_op",    32'(Operation), 32'h4);
        chk("bp_next_valid", 32'(out_valid), 32'd1);

        // Drain
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Flush coinciding with an illegal transfer
        ALUOp = 2'b01; Funct3 = 3'b010; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_cnt",   32'(illegal_count), 32'(exp_cnt));

        // Flush of a held result
        xfer("fh_or", 2'b10, 3'b110, 7'b0000000, 1'b0, 4'b0001, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b1;
        chk("flush_hold_valid", 32'(out_valid), 32'd0);

        // 300 back-to-back illegal transfers; count saturates at 255
        ALUOp = 2'b01; Funct3 = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_ill",   32'(illegal),   32'd1);
            chk("b2b_op",    32'(Operation), 32'd0);
            chk("b2b_cnt",   32'(illegal_count), 32'(exp_cnt));
        end
        chk("sat_cnt", 32'(illegal_count), 32'd255);

        // Asynchronous reset mid-cycle with a result held
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cnt",   32'(illegal_count), 32'd0);
        chk("arst_op",    32'(Operation), 32'd0);
        chk("arst_ill",   32'(illegal),   32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rel_valid", 32'(out_valid), 32'd0);
        chk("post_rel_ready", 32'(in_ready),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
